// File: rtl/whack_pkg.sv
// Shared types, type codes and grid geometry for the whack-a-mole spawner.
// Hole geometry helpers assume a 3-column grid, indices row-major.
package whack_pkg;

  typedef enum logic [1:0] {
    GAP   = 2'd0,
    SPAWN = 2'd1,
    UP    = 2'd2
  } mole_state_e;

  localparam logic [2:0] CHOICE_NORMAL = 3'b001;
  localparam logic [2:0] CHOICE_GOLDEN = 3'b100;
  localparam logic [2:0] CHOICE_BOMB   = 3'b011;

  localparam int          N_HOLES_D    = 9;
  localparam int          GRID_X0_D    = 128;
  localparam int          GRID_Y0_D    = 96;
  localparam int          PITCH_X_D    = 128;
  localparam int          PITCH_Y_D    = 112;
  localparam int          HOLE_W_D     = 64;
  localparam int          HOLE_H_D     = 64;
  localparam int          UP_FRAMES_D  = 60;
  localparam int          GAP_FRAMES_D = 20;
  localparam logic [15:0] LFSR_SEED_D  = 16'hACE1;

  // x^16 + x^14 + x^13 + x^11 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [2:0] type_from_nibble(input logic [3:0] n);
    logic [2:0] t;
    t = CHOICE_NORMAL;
    case (n)
      4'd0, 4'd1: t = CHOICE_GOLDEN;
      4'd2, 4'd3: t = CHOICE_BOMB;
      default:    t = CHOICE_NORMAL;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] hole_col(input logic [3:0] hole);
    logic [1:0] c;
    c = 2'd0;
    case (hole)
      4'd0, 4'd3, 4'd6: c = 2'd0;
      4'd1, 4'd4, 4'd7: c = 2'd1;
      default:          c = 2'd2;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] hole_row(input logic [3:0] hole);
    logic [1:0] r;
    r = 2'd0;
    case (hole)
      4'd0, 4'd1, 4'd2: r = 2'd0;
      4'd3, 4'd4, 4'd5: r = 2'd1;
      default:          r = 2'd2;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with the seed on reset.
module lfsr16
  import whack_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Shift right every cycle, folding the dropped bit back through the taps
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      q <= seed;
    end else if (q[0]) begin
      q <= (q >> 1) ^ LFSR_TAPS;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Spawns a random mole for a fixed number of frames and judges clicks against
// its hit-box; a hit yields a one-cycle CLICK_DOWN2 pulse carrying the type.
module mole_spawner
  import whack_pkg::*;
#(
  parameter int          N_HOLES    = N_HOLES_D,
  parameter int          GRID_X0    = GRID_X0_D,
  parameter int          GRID_Y0    = GRID_Y0_D,
  parameter int          PITCH_X    = PITCH_X_D,
  parameter int          PITCH_Y    = PITCH_Y_D,
  parameter int          HOLE_W     = HOLE_W_D,
  parameter int          HOLE_H     = HOLE_H_D,
  parameter int          UP_FRAMES  = UP_FRAMES_D,
  parameter int          GAP_FRAMES = GAP_FRAMES_D,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_D
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       frame_tick,
  input  logic       game_on,
  input  logic       CLICK,
  input  logic [9:0] MouseX,
  input  logic [9:0] MouseY,
  output logic       CLICK_DOWN2,
  output logic [2:0] choice,
  output logic       mole_active,
  output logic [3:0] mole_hole,
  output logic [2:0] mole_type
);

  localparam logic [3:0] HOLE_COUNT = 4'(N_HOLES);
  localparam logic [7:0] GAP_LIMIT  = 8'(GAP_FRAMES);
  localparam logic [7:0] UP_LIMIT   = 8'(UP_FRAMES);

  mole_state_e state_r, state_s;
  logic [7:0]  cnt_r, cnt_s, cnt_inc_s;
  logic [3:0]  prev_hole_r, prev_hole_s;
  logic        click_q_r;

  logic        pulse_s, active_s;
  logic [2:0]  choice_s, type_s;
  logic [3:0]  hole_s;

  logic [15:0] lfsr_q_s;
  logic        unused_lfsr_s;
  logic [3:0]  raw_hole_s, red_hole_s, spawn_hole_s;
  logic [2:0]  spawn_type_s;

  logic [10:0] x0_s, y0_s, mx_s, my_s;
  logic        in_box_s, rise_s, hit_s;

  lfsr16 u_lfsr (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .seed    (LFSR_SEED),
    .q       (lfsr_q_s)
  );

  assign unused_lfsr_s = ^lfsr_q_s[15:8];

  // Hole and type candidates for the next spawn, never repeating the last hole
  always_comb begin
    raw_hole_s   = lfsr_q_s[3:0];
    red_hole_s   = raw_hole_s;
    spawn_hole_s = raw_hole_s;
    if (raw_hole_s >= HOLE_COUNT) begin
      red_hole_s = raw_hole_s - HOLE_COUNT;
    end else begin
      red_hole_s = raw_hole_s;
    end
    if (red_hole_s == prev_hole_r) begin
      if (red_hole_s == HOLE_COUNT - 4'd1) begin
        spawn_hole_s = 4'd0;
      end else begin
        spawn_hole_s = red_hole_s + 4'd1;
      end
    end else begin
      spawn_hole_s = red_hole_s;
    end
    spawn_type_s = type_from_nibble(lfsr_q_s[7:4]);
  end

  // Hit-box test of the cursor against the current hole, on the click's rising edge
  always_comb begin
    x0_s     = 11'(GRID_X0) + 11'(hole_col(mole_hole)) * 11'(PITCH_X);
    y0_s     = 11'(GRID_Y0) + 11'(hole_row(mole_hole)) * 11'(PITCH_Y);
    mx_s     = {1'b0, MouseX};
    my_s     = {1'b0, MouseY};
    in_box_s = (mx_s >= x0_s) && (mx_s <= x0_s + 11'(HOLE_W) - 11'd1) &&
               (my_s >= y0_s) && (my_s <= y0_s + 11'(HOLE_H) - 11'd1);
    rise_s   = CLICK & ~click_q_r;
    hit_s    = (state_r == UP) && rise_s && in_box_s;
  end

  // Next-state and next-output logic; game_on low always wins, then hit, then timeout
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cnt_inc_s   = cnt_r + 8'd1;
    prev_hole_s = prev_hole_r;
    active_s    = mole_active;
    hole_s      = mole_hole;
    type_s      = mole_type;
    pulse_s     = 1'b0;
    choice_s    = 3'b000;
    case (state_r)
      GAP: begin
        active_s = 1'b0;
        if (!game_on) begin
          cnt_s = 8'd0;
        end else if (frame_tick) begin
          if (cnt_inc_s == GAP_LIMIT) begin
            state_s = SPAWN;
            cnt_s   = 8'd0;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      SPAWN: begin
        cnt_s = 8'd0;
        if (!game_on) begin
          state_s  = GAP;
          active_s = 1'b0;
        end else begin
          state_s     = UP;
          active_s    = 1'b1;
          hole_s      = spawn_hole_s;
          type_s      = spawn_type_s;
          prev_hole_s = spawn_hole_s;
        end
      end
      UP: begin
        if (!game_on) begin
          state_s  = GAP;
          active_s = 1'b0;
          cnt_s    = 8'd0;
        end else if (hit_s) begin
          state_s  = GAP;
          active_s = 1'b0;
          cnt_s    = 8'd0;
          pulse_s  = 1'b1;
          choice_s = mole_type;
        end else if (frame_tick) begin
          if (cnt_inc_s == UP_LIMIT) begin
            state_s  = GAP;
            active_s = 1'b0;
            cnt_s    = 8'd0;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s  = GAP;
        active_s = 1'b0;
        cnt_s    = 8'd0;
      end
    endcase
  end

  // State, frame counter, click history and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r     <= GAP;
      cnt_r       <= 8'd0;
      prev_hole_r <= 4'd0;
      click_q_r   <= 1'b0;
      CLICK_DOWN2 <= 1'b0;
      choice      <= 3'b000;
      mole_active <= 1'b0;
      mole_hole   <= 4'd0;
      mole_type   <= 3'b000;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      prev_hole_r <= prev_hole_s;
      click_q_r   <= CLICK;
      CLICK_DOWN2 <= pulse_s;
      choice      <= choice_s;
      mole_active <= active_s;
      mole_hole   <= hole_s;
      mole_type   <= type_s;
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Self-checking bench for mole_spawner: constant vectors, directed corner
// sequences and randomized traffic, all compared against a behavioural model.
module tb_mole_spawner;

  logic       CLK = 1'b0;
  logic       RESET_N, frame_tick, game_on, CLICK;
  logic [9:0] MouseX, MouseY;
  logic       CLICK_DOWN2, mole_active;
  logic [2:0] choice, mole_type;
  logic [3:0] mole_hole;

  int tests = 0;
  int fails = 0;

  mole_spawner dut (
    .CLK(CLK), .RESET_N(RESET_N), .frame_tick(frame_tick), .game_on(game_on),
    .CLICK(CLICK), .MouseX(MouseX), .MouseY(MouseY), .CLICK_DOWN2(CLICK_DOWN2),
    .choice(choice), .mole_active(mole_active), .mole_hole(mole_hole), .mole_type(mole_type)
  );

  always #5 CLK = ~CLK;

  // behavioural model: "pending" = spawn decision made, mole appears next edge
  logic [15:0] m_lfsr;
  bit          m_click_q, m_pending, m_active, m_pulse;
  int          m_frames, m_prev, m_hole;
  logic [2:0]  m_type, m_choice;

  function automatic int hx0(input int h); return 128 + (h % 3) * 128; endfunction
  function automatic int hy0(input int h); return 96 + (h / 3) * 112; endfunction

  function automatic bit over(input int mx, input int my, input int h);
    return mx >= hx0(h) && mx < hx0(h) + 64 && my >= hy0(h) && my < hy0(h) + 64;
  endfunction

  function automatic logic [2:0] kind(input int n);
    if (n < 2) return 3'b100;
    else if (n < 4) return 3'b011;
    else return 3'b001;
  endfunction

  task automatic model_step(input bit rn, input bit gon, input bit tick, input bit ck,
                            input int mx, input int my);
    logic [15:0] cur;
    bit rise;
    int h;
    cur    = m_lfsr;
    m_lfsr = (cur >> 1) ^ (cur[0] ? 16'hB400 : 16'h0000);
    if (!rn) begin
      m_lfsr = 16'hACE1; m_click_q = 1'b0; m_pending = 1'b0; m_active = 1'b0;
      m_pulse = 1'b0; m_frames = 0; m_prev = 0; m_hole = 0; m_type = 3'b000;
      m_choice = 3'b000;
    end else begin
      rise = ck && !m_click_q;
      m_click_q = ck;
      m_pulse = 1'b0;
      m_choice = 3'b000;
      if (m_pending) begin
        m_pending = 1'b0;
        m_frames = 0;
        if (gon) begin
          h = int'(cur[3:0]) % 16;
          if (h >= 9) h = h - 9;
          if (h == m_prev) h = (h + 1) % 9;
          m_hole = h; m_prev = h; m_type = kind(int'(cur[7:4])); m_active = 1'b1;
        end
      end else if (m_active) begin
        if (!gon) begin
          m_active = 1'b0; m_frames = 0;
        end else if (rise && over(mx, my, m_hole)) begin
          m_pulse = 1'b1; m_choice = m_type; m_active = 1'b0; m_frames = 0;
        end else if (tick) begin
          m_frames++;
          if (m_frames == 60) begin m_active = 1'b0; m_frames = 0; end
        end
      end else begin
        if (!gon) m_frames = 0;
        else if (tick) begin
          m_frames++;
          if (m_frames == 20) begin m_pending = 1'b1; m_frames = 0; end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // one clock: drive, advance model at the edge, compare all outputs 1 time unit later
  task automatic cyc(input bit rn, input bit gon, input bit tick, input bit ck,
                     input int mx, input int my);
    RESET_N = rn; game_on = gon; frame_tick = tick; CLICK = ck;
    MouseX = 10'(mx); MouseY = 10'(my);
    @(posedge CLK);
    model_step(rn, gon, tick, ck, mx, my);
    #1;
    check("model_outputs",
          {20'd0, CLICK_DOWN2, choice, mole_active, mole_hole, mole_type},
          {20'd0, m_pulse, m_choice, m_active, 4'(m_hole), m_type});
  endtask

  task automatic wait_mole();
    int n;
    n = 0;
    while (mole_active !== 1'b1 && n < 100) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
      n++;
    end
    check("mole_appears_in_budget", {31'd0, mole_active}, 32'd1);
  endtask

  typedef struct {
    bit         rn, gon, tick, ck;
    int         mx, my;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   hx, hy, pulses, prev_hole, seen_gold, seen_bomb, seen_norm, up_seen;
  logic [2:0] want_type;
  bit   rn_r, gon_r, tk_r, ck_r;
  int   mx_r, my_r;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 0,   0,   12'h000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 280, 230, 12'h000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 280, 230, 12'h000};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 10,  10,  12'h000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 10,  10,  12'h000};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 150, 120, 12'h000};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 150, 120, 12'h000};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 280, 230, 12'h000};
    for (int i = 0; i < 8; i++) begin
      cyc(vecs[i].rn, vecs[i].gon, vecs[i].tick, vecs[i].ck, vecs[i].mx, vecs[i].my);
      check($sformatf("vector_%0d", i),
            {20'd0, CLICK_DOWN2, choice, mole_active, mole_hole, mole_type}, {20'd0, vecs[i].exp});
    end

    // first spawn: 20 ticks -> SPAWN, mole visible one cycle later
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check("active_low_in_spawn_cycle", {31'd0, mole_active}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    check("active_after_spawn", {31'd0, mole_active}, 32'd1);
    check("hole_in_range", {31'd0, mole_hole <= 4'd8}, 32'd1);

    // miss far away, then hit centre
    hx = hx0(m_hole); hy = hy0(m_hole); want_type = m_type;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 10, 10);
    check("miss_no_pulse", {31'd0, CLICK_DOWN2}, 32'd0);
    check("miss_still_active", {31'd0, mole_active}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, hx + 24, hy + 22);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, hx + 24, hy + 22);
    check("hit_pulse", {31'd0, CLICK_DOWN2}, 32'd1);
    check("hit_choice", {29'd0, choice}, {29'd0, want_type});
    check("hit_clears_active", {31'd0, mole_active}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, hx + 24, hy + 22);
    check("pulse_one_cycle", {28'd0, CLICK_DOWN2, choice}, 32'd0);

    // click with no mole up
    cyc(1'b1, 1'b1, 1'b0, 1'b0, hx + 24, hy + 22);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, hx + 24, hy + 22);
    check("no_mole_click", {31'd0, CLICK_DOWN2}, 32'd0);

    // hit-box edges
    wait_mole();
    hx = hx0(m_hole); hy = hy0(m_hole);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, hx + 64, hy);
    check("edge_x_plus_64_miss", {31'd0, CLICK_DOWN2}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, hx - 1, hy + 63);
    check("edge_x_minus_1_miss", {31'd0, CLICK_DOWN2}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, hx, hy + 64);
    check("edge_y_plus_64_miss", {31'd0, CLICK_DOWN2}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, hx + 63, hy + 63);
    check("edge_corner_hit", {31'd0, CLICK_DOWN2}, 32'd1);

    // held button: exactly one pulse
    wait_mole();
    hx = hx0(m_hole); hy = hy0(m_hole); pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, hx + 5, hy + 5);
      if (CLICK_DOWN2 === 1'b1) pulses++;
    end
    check("held_single_pulse", pulses, 32'd1);

    // timeout, then the next hole differs
    wait_mole();
    prev_hole = m_hole;
    for (int i = 0; i < 59; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check("up_before_timeout", {31'd0, mole_active}, 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check("timeout_clears", {28'd0, CLICK_DOWN2, 2'b00, mole_active}, 32'd0);
    wait_mole();
    check("new_hole_differs", {31'd0, 32'(mole_hole) != prev_hole}, 32'd1);

    // hit on the timeout tick wins
    hx = hx0(m_hole); hy = hy0(m_hole);
    for (int i = 0; i < 59; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, hx + 1, hy + 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, hx + 1, hy + 1);
    check("hit_beats_timeout", {31'd0, CLICK_DOWN2}, 32'd1);

    // game_on falls during UP
    wait_mole();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    check("game_off_clears", {28'd0, CLICK_DOWN2, 2'b00, mole_active}, 32'd0);

    // reset during UP, then 100 ticks with game off
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    wait_mole();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    check("reset_mid_mole",
          {20'd0, CLICK_DOWN2, choice, mole_active, mole_hole, mole_type}, 32'd0);
    up_seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
      if (mole_active !== 1'b0) up_seen++;
    end
    check("game_off_no_spawn", up_seen, 32'd0);

    // randomized traffic, aimed at the mole most of the time
    seen_gold = 0; seen_bomb = 0; seen_norm = 0;
    for (int i = 0; i < 6000; i++) begin
      rn_r  = ($urandom_range(0, 499) != 0);
      gon_r = ($urandom_range(0, 59) != 0);
      tk_r  = 1'($urandom_range(0, 1));
      ck_r  = 1'($urandom_range(0, 1));
      if (m_active && $urandom_range(0, 3) != 0) begin
        mx_r = hx0(m_hole) + int'($urandom_range(0, 63));
        my_r = hy0(m_hole) + int'($urandom_range(0, 63));
      end else begin
        mx_r = int'($urandom_range(0, 1023));
        my_r = int'($urandom_range(0, 1023));
      end
      cyc(rn_r, gon_r, tk_r, ck_r, mx_r, my_r);
      if (CLICK_DOWN2 === 1'b1 && choice === 3'b100) seen_gold++;
      if (CLICK_DOWN2 === 1'b1 && choice === 3'b011) seen_bomb++;
      if (CLICK_DOWN2 === 1'b1 && choice === 3'b001) seen_norm++;
    end
    check("random_saw_golden", {31'd0, seen_gold > 0}, 32'd1);
    check("random_saw_bomb", {31'd0, seen_bomb > 0}, 32'd1);
    check("random_saw_normal", {31'd0, seen_norm > 0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
